// File: rtl/im_loader.sv
// im_loader: boot-time writer for the instruction memory.
// Takes a byte stream (2-byte little-endian word count, then the image), packs
// little-endian 32-bit words and writes them one per strobe. The core stays held
// (cpu_run=0) until every word of the image has been written.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        single-cycle load request (ignored while busy)
//   byte_valid   byte_data holds a valid byte
//   byte_data    stream byte
//   byte_ready   loader accepts a byte this cycle
//   IMwaddress   instruction memory byte address (word aligned)
//   IMwdata      word to write
//   IMwenable    write strobe, one cycle per word
//   cpu_run      1 = core released, 0 = core held
//   busy         load in progress
//   done         last load completed successfully
//   error        last load aborted (oversize header or idle timeout)
//   words_loaded words written in the current/last load
module im_loader #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [31:0] IMwaddress,
  output logic [31:0] IMwdata,
  output logic        IMwenable,
  output logic        cpu_run,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TMR_W  = 16;
  localparam int unsigned LANE_W = 2;
  localparam logic [CNT_W:0] DEPTH_LIM   = (CNT_W+1)'(DEPTH);
  localparam logic [TMR_W:0] TIMEOUT_LIM = (TMR_W+1)'(TIMEOUT);
  localparam logic           TIMEOUT_EN  = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    count_q, count_n;
  logic [LANE_W-1:0]   lane_q, lane_n;
  logic [TMR_W-1:0]    timer_q, timer_n;
  logic [CNT_W-1:0]    wl_n;
  logic [31:0]         addr_n, data_n;
  logic                ready_n, wen_n, run_n, busy_n, done_n, error_n;

  logic                xfer_c;
  logic                loading_c;
  logic [CNT_W-1:0]    hdr_c;
  logic [TMR_W:0]      timer_inc_c;
  logic [CNT_W-1:0]    wl_inc_c;

  // A transfer uses the registered ready, so it always matches the current state.
  assign xfer_c      = byte_valid & byte_ready;
  assign loading_c   = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA);
  assign hdr_c       = {byte_data, count_q[7:0]};
  assign timer_inc_c = (TMR_W+1)'(timer_q) + (TMR_W+1)'(1);
  assign wl_inc_c    = words_loaded + CNT_W'(1);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state, datapath next values and output decode.
  always_comb begin
    state_n = state;
    count_n = count_q;
    lane_n  = lane_q;
    timer_n = timer_q;
    wl_n    = words_loaded;
    addr_n  = IMwaddress;
    data_n  = IMwdata;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_n = S_HDR0;
          wl_n    = '0;
          timer_n = '0;
        end
      end
      S_HDR0: begin
        if (xfer_c) begin
          count_n[7:0] = byte_data;
          timer_n      = '0;
          state_n      = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer_c) begin
          count_n = hdr_c;
          timer_n = '0;
          lane_n  = '0;
          // Header compared in CNT_W+1 bits so a large count cannot wrap past DEPTH.
          if (hdr_c == '0)                           state_n = S_DONE;
          else if ((CNT_W+1)'(hdr_c) > DEPTH_LIM)     state_n = S_ERR;
          else                                       state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          data_n[{lane_q, 3'b000} +: 8] = byte_data;
          lane_n  = lane_q + LANE_W'(1);
          timer_n = '0;
          if (lane_q == LANE_W'(3)) begin
            state_n = S_WRITE;
            addr_n  = {14'd0, words_loaded, 2'b00};
          end
        end
      end
      S_WRITE: begin
        wl_n   = wl_inc_c;
        lane_n = '0;
        if (wl_inc_c == count_q) state_n = S_DONE;
        else                     state_n = S_DATA;
      end
      default: state_n = S_IDLE;
    endcase

    // Idle timer: counts loading cycles with no transfer; a partial word is dropped on abort.
    if (loading_c && !xfer_c) begin
      timer_n = timer_inc_c[TMR_W-1:0];
      if (TIMEOUT_EN && (timer_inc_c == TIMEOUT_LIM)) state_n = S_ERR;
    end

    // Outputs are registered from the next state so they line up with it.
    ready_n = (state_n == S_HDR0) || (state_n == S_HDR1) || (state_n == S_DATA);
    wen_n   = (state_n == S_WRITE);
    busy_n  = ready_n || wen_n;
    done_n  = (state_n == S_DONE);
    run_n   = (state_n == S_DONE);
    error_n = (state_n == S_ERR);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q      <= '0;
      lane_q       <= '0;
      timer_q      <= '0;
      words_loaded <= '0;
      IMwaddress   <= '0;
      IMwdata      <= '0;
      byte_ready   <= 1'b0;
      IMwenable    <= 1'b0;
      cpu_run      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      count_q      <= count_n;
      lane_q       <= lane_n;
      timer_q      <= timer_n;
      words_loaded <= wl_n;
      IMwaddress   <= addr_n;
      IMwdata      <= data_n;
      byte_ready   <= ready_n;
      IMwenable    <= wen_n;
      cpu_run      <= run_n;
      busy         <= busy_n;
      done         <= done_n;
      error        <= error_n;
    end
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time writer for the processor's instruction memory; the memory's write-side counterpart to the fetch path that reads it.
- Accepts a byte stream on a valid/ready handshake: a 2-byte word-count header, then the program image.
- Assembles little-endian 32-bit words and drives the instruction-memory write port.
- Holds the core stopped until the image is complete.

Parameters:
- DEPTH, 256, instruction memory capacity in 32-bit words; header count above this is an error
- TIMEOUT, 65535, max idle cycles between accepted bytes while loading before abort; 0 disables

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle load request
- byte_valid  input  1  byte_data holds a valid byte
- byte_data  input  8  stream byte
- byte_ready  output  1  loader can accept a byte this cycle
- IMwaddress  output  32  instruction memory byte address, word aligned
- IMwdata  output  32  word to write
- IMwenable  output  1  write strobe, one cycle per word
- cpu_run  output  1  1 = core released from hold; 0 = core held in reset
- busy  output  1  load in progress
- done  output  1  last load completed successfully
- error  output  1  last load aborted
- words_loaded  output  16  words written in current/last load

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE
  - byte_ready, IMwenable, cpu_run, busy, done, error = 0
  - IMwaddress, IMwdata, words_loaded = 0
  - internal count N, lane counter, idle timer = 0
- Byte transfer: occurs on a rising edge with byte_valid=1 and byte_ready=1. byte_data is ignored otherwise.
- All outputs are registered.
- byte_ready=1 only in HDR0, HDR1, DATA.
- States:
  - IDLE: start=1 -> HDR0.
  - HDR0: on transfer, N[7:0]=byte -> HDR1.
  - HDR1: on transfer, N[15:8]=byte. Next state:
    - N==0 -> DONE
    - N>DEPTH -> ERR
    - else -> DATA, lane=0
  - DATA: on transfer, byte goes to IMwdata[8*lane+7:8*lane] and lane increments. Lane 3 transfer -> WRITE.
  - WRITE (exactly one cycle):
    - IMwenable=1, IMwaddress=words_loaded<<2, IMwdata holds assembled word, byte_ready=0.
    - Next edge: words_loaded+1; words_loaded+1==N -> DONE, else -> DATA, lane=0.
  - DONE: done=1, cpu_run=1, busy=0. start=1 -> HDR0.
  - ERR: error=1, cpu_run=0, busy=0. start=1 -> HDR0.
- Entering HDR0 from any state:
  - words_loaded=0, done=0, error=0, cpu_run=0, busy=1 on the same edge.
  - busy stays 1 through HDR0, HDR1, DATA, WRITE.
- start is ignored while busy=1.
- Latency:
  - Word k's write strobe asserts the cycle after its 4th byte transfer.
  - Back-to-back bytes give one word per 5 cycles.
  - done rises the cycle after the last WRITE.
- Timeout:
  - Idle timer clears on every transfer and on entry to HDR0.
  - It increments each cycle in HDR0/HDR1/DATA without a transfer.
  - When it reaches TIMEOUT (TIMEOUT!=0): -> ERR. A partial word is not written.
- Boundaries:
  - N==DEPTH is legal; last address (DEPTH-1)*4.
  - The 17-bit comparison of N against DEPTH has no wrap.
  - A byte presented during WRITE is held by the source (byte_ready=0) and is not lost.
  - reset asserted mid-load returns to IDLE with cpu_run=0. Partial memory contents are left as written.
  - IMwenable is never asserted outside WRITE.

Test Plan:
- Reset, then start, stream 02 00 13 05 50 00 93 05 A0 00 back-to-back -> two strobes: addr 0x0 data 0x00500513, addr 0x4 data 0x00A00593; done=1, cpu_run=1, words_loaded=2.
- Header 00 00 -> DONE with no IMwenable pulse, words_loaded=0, cpu_run=1.
- Header DEPTH+1 (01 01 with DEPTH=256) -> ERR, error=1, cpu_run=0, byte_ready=0, no write.
- TIMEOUT=16, header 01 00 then 2 bytes then idle -> ERR exactly 16 cycles after last transfer, no write; second start plus full stream -> done=1, error=0.
- Random byte_valid gaps and start pulses during busy -> data identical to the gap-free case, start ignored, one strobe per word.
- Assert reset mid-DATA after 1 word written -> all outputs reset values immediately, no further strobes.
